// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port shared by writeback and a queued auxiliary source
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_reg_en,
  input  logic [4:0]               wb_reg_addr,
  input  logic [31:0]              wb_reg_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_addr,
  input  logic [31:0]              aux_data,
  output logic                     rf_we,
  output logic [4:0]               rf_addr,
  output logic [31:0]              rf_data,
  output logic                     arb_stall,
  output logic [$clog2(DEPTH):0]   aux_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_wait;

  logic w_empty;
  logic w_full;
  logic w_stall;
  logic w_wb_grant;
  logic w_push;
  logic w_pop;
  logic w_push_live;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_stall    = !w_empty && (r_wait == 4'(MAX_WAIT));
  assign w_wb_grant = wb_reg_en && (wb_reg_addr != 5'd0) && !w_stall;
  assign w_pop      = !w_wb_grant && !w_empty;
  assign w_push     = aux_valid && !w_full;
  // A push to the register writeback is overwriting this cycle is already stale.
  assign w_push_live = (aux_addr != 5'd0) && !(w_wb_grant && (aux_addr == wb_reg_addr));

  assign aux_ready = !w_full;
  assign arb_stall = w_stall;
  assign aux_count = r_count;

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (w_wb_grant) begin
      rf_we   = 1'b1;
      rf_addr = wb_reg_addr;
      rf_data = wb_reg_data;
    end else if (w_pop && r_live[r_rd_ptr]) begin
      rf_we   = 1'b1;
      rf_addr = r_addr[r_rd_ptr];
      rf_data = r_data[r_rd_ptr];
    end
    if (reset) begin
      rf_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_addr[r_wr_ptr] <= aux_addr;
      r_data[r_wr_ptr] <= aux_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wait   <= 4'd0;
      r_live   <= '0;
    end else begin
      // Writeback is program-newer, so it kills any queued write to the same register.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wb_grant && (r_addr[i] == wb_reg_addr)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_push) begin
        r_live[r_wr_ptr] <= w_push_live;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_empty || w_pop) begin
        r_wait <= 4'd0;
      end else if (r_wait < 4'(MAX_WAIT)) begin
        r_wait <= r_wait + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized bench for regfile_write_arbiter against a queue-based model
module tb_regfile_write_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clock;
  logic        reset;
  logic        wb_reg_en;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_reg_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_addr;
  logic [31:0] aux_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        arb_stall;
  logic [$clog2(DEPTH):0] aux_count;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset),
    .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr), .wb_reg_data(wb_reg_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .arb_stall(arb_stall), .aux_count(aux_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          mwait;
  int          n_chk;
  int          n_err;
  logic [31:0] dut_rf [32];
  int          aux_writes;
  logic        obs_we;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data;
  logic        obs_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [4:0] wa, input logic [31:0] wd,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad);
    bit          exp_stall, wbg, pop, exp_we;
    logic [4:0]  ea;
    logic [31:0] ed;
    int          n0;
    @(negedge clock);
    reset = rst; wb_reg_en = en; wb_reg_addr = wa; wb_reg_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    #1;
    exp_stall = (mq.size() > 0) && (mwait == MAX_WAIT);
    wbg = en && (wa != 5'd0) && !exp_stall;
    pop = !wbg && (mq.size() > 0);
    exp_we = 1'b0; ea = 5'd0; ed = 32'd0;
    if (wbg) begin
      exp_we = 1'b1; ea = wa; ed = wd;
    end else if (pop && mq[0].live) begin
      exp_we = 1'b1; ea = mq[0].a; ed = mq[0].d;
    end
    if (rst) exp_we = 1'b0;
    check("aux_ready", 64'(aux_ready), 64'(mq.size() < DEPTH));
    check("aux_count", 64'(aux_count), 64'(mq.size()));
    check("arb_stall", 64'(arb_stall), 64'(exp_stall));
    check("rf_we", 64'(rf_we), 64'(exp_we));
    if (!rst && (exp_we || !pop)) begin
      check("rf_addr", 64'(rf_addr), 64'(ea));
      check("rf_data", 64'(rf_data), 64'(ed));
    end
    obs_we = rf_we; obs_addr = rf_addr; obs_data = rf_data; obs_stall = arb_stall;
    if (rf_we) begin
      dut_rf[rf_addr] = rf_data;
      if (!wbg) aux_writes++;
    end
    if (rst) begin
      mq.delete();
      mwait = 0;
    end else begin
      n0 = mq.size();
      if (wbg) foreach (mq[i]) if (mq[i].a == wa) mq[i].live = 1'b0;
      if (pop) void'(mq.pop_front());
      if (av && n0 < DEPTH) mq.push_back('{aa, ad, (aa != 5'd0) && !(wbg && aa == wa)});
      if (n0 == 0 || pop) mwait = 0;
      else if (mwait < MAX_WAIT) mwait++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int stall_at[$];
    bit last_stall;
    bit en_r;
    logic [4:0]  wa_r;
    logic [31:0] wd_r;
    n_chk = 0; n_err = 0; mwait = 0; aux_writes = 0;
    foreach (dut_rf[i]) dut_rf[i] = 32'd0;
    reset = 1'b1; wb_reg_en = 1'b0; wb_reg_addr = 5'd0; wb_reg_data = 32'd0;
    aux_valid = 1'b0; aux_addr = 5'd0; aux_data = 32'd0;
    repeat (2) @(posedge clock);

    idle();
    check("reset_we", 64'(obs_we), 64'd0);
    check("reset_stall", 64'(obs_stall), 64'd0);

    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("pass_we", 64'(obs_we), 64'd1);
    check("pass_addr", 64'(obs_addr), 64'd5);
    check("pass_data", 64'(obs_data), 64'hDEADBEEF);

    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    check("nobypass_we", 64'(obs_we), 64'd0);
    idle();
    check("aux_we", 64'(obs_we), 64'd1);
    check("aux_addr", 64'(obs_addr), 64'd7);
    check("aux_data", 64'(obs_data), 64'h11);
    idle();
    check("aux_drained", 64'(aux_count), 64'd0);

    for (int s = 0; s < 12; s++) begin
      step(1'b0, 1'b1, 5'd3, 32'h33, s < 2, 5'(20 + s), 32'(100 + s));
      if (s == 2) check("full_ready", 64'(aux_ready), 64'd0);
      if (obs_stall) stall_at.push_back(s);
    end
    check("stall_count", 64'(stall_at.size()), 64'd2);
    if (stall_at.size() == 2) begin
      check("stall_first", 64'(stall_at[0]), 64'd5);
      check("stall_second", 64'(stall_at[1]), 64'd10);
    end
    check("starve_rf20", 64'(dut_rf[20]), 64'd100);
    check("starve_rf21", 64'(dut_rf[21]), 64'd101);
    idle();

    dut_rf[9] = 32'd0; dut_rf[10] = 32'd0;
    step(1'b0, 1'b1, 5'd3, 32'h1, 1'b1, 5'd9, 32'hAA);
    step(1'b0, 1'b1, 5'd9, 32'hBB, 1'b1, 5'd10, 32'hCC);
    idle();
    check("squash_we", 64'(obs_we), 64'd0);
    idle();
    idle();
    check("hazard_rf9", 64'(dut_rf[9]), 64'hBB);
    check("hazard_rf10", 64'(dut_rf[10]), 64'hCC);

    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    idle();
    check("zero_aux_we", 64'(obs_we), 64'd0);
    step(1'b0, 1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'd0);
    check("zero_wb_we", 64'(obs_we), 64'd0);

    aux_writes = 0;
    step(1'b0, 1'b1, 5'd3, 32'h2, 1'b1, 5'd12, 32'h120);
    step(1'b0, 1'b1, 5'd3, 32'h2, 1'b1, 5'd13, 32'h130);
    step(1'b1, 1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0);
    check("rst_we", 64'(obs_we), 64'd0);
    for (int s = 0; s < 6; s++) idle();
    check("rst_count", 64'(aux_count), 64'd0);
    check("rst_no_aux_writes", 64'(aux_writes), 64'd0);

    last_stall = 1'b0; en_r = 1'b0; wa_r = 5'd0; wd_r = 32'd0;
    for (int k = 0; k < 3000; k++) begin
      if (!last_stall) begin
        en_r = ($urandom_range(0, 9) < 7);
        wa_r = 5'($urandom_range(0, 12));
        wd_r = $urandom;
      end
      step($urandom_range(0, 99) == 0, en_r, wa_r, wd_r,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 12)), $urandom);
      last_stall = obs_stall;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port between the pipeline writeback stage and an auxiliary long-latency result source, such as a multiply/divide unit or a coprocessor load return. Writeback traffic has priority and passes straight through with zero latency. Auxiliary results are queued in a small FIFO and drained into idle write slots. A starvation counter forces a one-cycle pipeline stall so auxiliary results cannot wait indefinitely.

Parameters:
DEPTH, 2, auxiliary FIFO entries (power of two, 2..8)
MAX_WAIT, 4, cycles a non-empty FIFO head may wait before a forced stall (1..15)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
wb_reg_en  input  1  writeback stage requests a register write
wb_reg_addr  input  5  writeback destination register
wb_reg_data  input  32  writeback value
aux_valid  input  1  auxiliary source presents a result
aux_ready  output  1  arbiter can accept an auxiliary result this cycle
aux_addr  input  5  auxiliary destination register
aux_data  input  32  auxiliary value
rf_we  output  1  register-file write enable
rf_addr  output  5  register-file write address
rf_data  output  32  register-file write data
arb_stall  output  1  pipeline must hold its writeback contents this cycle
aux_count  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- One clock domain, named clock. Reset is synchronous and active-high, named reset.
- Reset, evaluated at the clock edge:
  - FIFO pointers, count and kill bits cleared; wait counter cleared.
  - After reset: aux_count=0, aux_ready=1, arb_stall=0.
  - rf_we=0 while reset is high.
  - A reset asserted mid-operation discards all queued entries without writing them.
- FIFO: circular, DEPTH entries, each holding {addr, data, live}.
  - aux_ready = (count != DEPTH).
  - Push occurs when aux_valid && aux_ready.
  - A pushed entry with aux_addr==0 is stored with live=0: it occupies a slot but is never written.
- There is no same-cycle bypass. A result pushed in cycle N is first writable in cycle N+1.
- Grant is combinational, evaluated each cycle:
  - WB_GRANT: wb_reg_en=1, wb_reg_addr!=0 and arb_stall=0. The port drives rf_we=1 and rf_addr/rf_data = the wb_reg_* inputs.
  - AUX_GRANT: otherwise, if the FIFO is non-empty. The head pops.
    - If the head's live=1: rf_we=1 and rf_addr/rf_data = head entry.
    - If the head's live=0: the head still pops, with rf_we=0.
  - IDLE: rf_we=0; rf_addr/rf_data = 0.
- Writes to register $0 from writeback are never forwarded (rf_we=0). Such a cycle counts as an idle slot for the FIFO.
- Ordering hazard (writeback is program-newer):
  - On WB_GRANT to address X, every queued entry with addr==X has live cleared at that edge.
  - A same-cycle push to X is also stored with live=0.
  - Dead entries drain through AUX_GRANT slots.
- Push and pop in the same cycle are allowed when the FIFO is not full; count is unchanged.
- When full, push is blocked even if a pop occurs that cycle (aux_ready depends only on count).
- Wait counter, 4 bits:
  - Clears when the FIFO is empty or a pop occurs.
  - Otherwise increments by 1, saturating at MAX_WAIT.
- Forced stall:
  - arb_stall=1 (combinational) when wait==MAX_WAIT and the FIFO is non-empty.
  - In that cycle AUX_GRANT wins regardless of wb_reg_en.
  - The pipeline contract is that writeback inputs are held and re-presented next cycle.
  - The stall lasts exactly one cycle, because the pop clears the counter.
- aux_count reflects the registered count (value after the last edge).

Test Plan:
- Reset, then idle → aux_ready=1, aux_count=0, rf_we=0, arb_stall=0.
- Writeback pass-through: wb_reg_en=1, addr=5, data=0xDEADBEEF → same cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF.
- Aux into idle port: push addr=7, data=0x11 in cycle N with wb_reg_en=0 → rf_we=1, rf_addr=7, rf_data=0x11 in cycle N+1; aux_count returns to 0.
- Full and starvation, DEPTH=2, MAX_WAIT=4, wb_reg_en held at 1 (addr=3):
  - Two pushes fill the FIFO → aux_ready=0.
  - After 4 waiting cycles, arb_stall=1 for one cycle and the head is written.
  - The FIFO drains 1 entry per MAX_WAIT+1 cycles while writeback stays busy.
- Hazard squash:
  - Queue addr=9, data=0xAA, then writeback writes addr=9, data=0xBB → the queued entry is dropped and the register ends at 0xBB.
  - Queued addr=10 is unaffected and is written later.
- $0 and mid-operation reset:
  - Push aux addr=0 → it pops with rf_we=0.
  - Writeback addr=0 → rf_we=0.
  - Fill the FIFO, assert reset for one cycle → aux_count=0 and no queued entry is ever written.
